// File: rtl/nibble_adder_arbiter.sv
// Round-robin arbiter sharing one registered W-bit adder among NREQ requesters; optional ADDARB_SATURATE_EN saturates on carry.
// Latency: grant/handshake in cycle N, tagged response valid in cycle N+2; at most one operation per 3 cycles.
// Backpressure: rsp_ready low holds the response stable and withholds all grants until it is accepted.
module nibble_adder_arbiter #(
   parameter int NREQ = 4,
   parameter int W    = 4,
   parameter int ID_W = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [NREQ*W-1:0] req_a,
   input  logic [NREQ*W-1:0] req_b,
   output logic [NREQ-1:0]   req_ready,
   output logic              rsp_valid,
   output logic [ID_W-1:0]   rsp_id,
   output logic [W:0]        rsp_sum,
   input  logic              rsp_ready,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t          state_q, state_d;
   logic [ID_W-1:0] last_q, last_d;
   logic [ID_W-1:0] gid_q, gid_d;
   logic [ID_W-1:0] id_q, id_d;
   logic [W-1:0]    a_q, a_d;
   logic [W-1:0]    b_q, b_d;
   logic [W:0]      sum_q, sum_d;

   logic [ID_W-1:0] win;
   logic            win_vld;
   logic [ID_W-1:0] idx;
   logic [W:0]      raw_sum;
   logic [W:0]      result;

   // Round-robin search: first valid requester starting just after the last winner.
   always_comb begin
      win     = '0;
      win_vld = 1'b0;
      idx     = '0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = ID_W'((int'(last_q) + k) % NREQ);
         if (!win_vld && req_valid[idx]) begin
            win_vld = 1'b1;
            win     = idx;
         end
      end
   end

   // Adder on the captured operands; carry either kept as MSB or folded into saturation.
   always_comb begin
      raw_sum = {1'b0, a_q} + {1'b0, b_q};
`ifdef ADDARB_SATURATE_EN
      result  = raw_sum[W] ? {1'b1, {W{1'b1}}} : raw_sum;
`else
      result  = raw_sum;
`endif
   end

   // Next-state and handshake outputs; grants are only issued from IDLE.
   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      gid_d     = gid_q;
      id_d      = id_q;
      a_d       = a_q;
      b_d       = b_q;
      sum_d     = sum_q;
      req_ready = '0;
      rsp_valid = 1'b0;
      case (state_q)
         IDLE: begin
            if (win_vld) begin
               req_ready[win] = 1'b1;
               a_d            = req_a[int'(win)*W +: W];
               b_d            = req_b[int'(win)*W +: W];
               gid_d          = win;
               last_d         = win;
               state_d        = EXEC;
            end
         end
         EXEC: begin
            sum_d   = result;
            id_d    = gid_q;
            state_d = RESP;
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; pointer resets so requester 0 wins first.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         last_q  <= ID_W'(NREQ - 1);
         gid_q   <= '0;
         id_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         gid_q   <= gid_d;
         id_q    <= id_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
      end
   end

   assign rsp_id  = id_q;
   assign rsp_sum = sum_q;
   assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_nibble_adder_arbiter.sv
// Directed self-checking bench for nibble_adder_arbiter (NREQ=4, W=4).
// Inputs driven 1 time unit after each rising edge; outputs sampled right after.
// Expected sum for F+F follows ADDARB_SATURATE_EN.
module tb_nibble_adder_arbiter;

   logic        clk;
   logic        rst_n;
   logic [3:0]  req_valid;
   logic [15:0] req_a;
   logic [15:0] req_b;
   logic [3:0]  req_ready;
   logic        rsp_valid;
   logic [1:0]  rsp_id;
   logic [4:0]  rsp_sum;
   logic        rsp_ready;
   logic        busy;

   int checks;
   int failures;

   logic [1:0]  order [5];
   logic [4:0]  held_sum;
   logic [1:0]  held_id;

   nibble_adder_arbiter #(.NREQ(4), .W(4), .ID_W(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_id    (rsp_id),
      .rsp_sum   (rsp_sum),
      .rsp_ready (rsp_ready),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      order[0]  = 2'd0;
      order[1]  = 2'd1;
      order[2]  = 2'd2;
      order[3]  = 2'd3;
      order[4]  = 2'd0;
      rst_n     = 1'b0;
      req_valid = 4'b0000;
      req_a     = 16'h0000;
      req_b     = 16'h0000;
      rsp_ready = 1'b0;

      // Reset state
      #3;
      check("rst_req_ready", 32'(req_ready), 32'h0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      check("rst_rsp_id",    32'(rsp_id),    32'h0);
      check("rst_rsp_sum",   32'(rsp_sum),   32'h0);
      check("rst_busy",      32'(busy),      32'h0);
      tick();
      rst_n = 1'b1;
      tick();

      // Single requester 2: 7 + 5, operands changed after handshake
      req_valid = 4'b0100;
      req_a     = 16'h0700;
      req_b     = 16'h0500;
      #1;
      check("t1_grant", 32'(req_ready), 32'h4);
      check("t1_busy_idle", 32'(busy), 32'h0);
      tick();
      req_valid = 4'b0000;
      req_a     = 16'h0F00;
      req_b     = 16'h0F00;
      #1;
      check("t1_exec_busy",  32'(busy),      32'h1);
      check("t1_exec_valid", 32'(rsp_valid), 32'h0);
      check("t1_exec_ready", 32'(req_ready), 32'h0);
      tick();
      check("t1_rsp_valid", 32'(rsp_valid), 32'h1);
      check("t1_rsp_id",    32'(rsp_id),    32'h2);
      check("t1_rsp_sum",   32'(rsp_sum),   32'h0C);
      rsp_ready = 1'b1;
      tick();
      check("t1_back_idle_valid", 32'(rsp_valid), 32'h0);
      check("t1_back_idle_busy",  32'(busy),      32'h0);

      // Round-robin after reset with all requesters asserting
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      req_a     = 16'h4321;   // requester i: a = i+1
      req_b     = 16'h5432;   // requester i: b = i+2, sum = 2i+3
      req_valid = 4'b1111;
      rsp_ready = 1'b1;
      #1;
      for (int n = 0; n < 5; n++) begin
         check("rr_grant", 32'(req_ready), 32'(4'b0001 << order[n]));
         tick();
         check("rr_exec_busy", 32'(busy), 32'h1);
         tick();
         check("rr_rsp_id",  32'(rsp_id),  32'(order[n]));
         check("rr_rsp_sum", 32'(rsp_sum), 32'(2 * order[n] + 3));
         tick();
      end

      // F + F on requester 1, then 5 cycles of backpressure in RESP
      req_valid = 4'b0010;
      req_a     = 16'h00F0;
      req_b     = 16'h00F0;
      rsp_ready = 1'b0;
      #1;
      check("t3_grant", 32'(req_ready), 32'h2);
      tick();
      req_valid = 4'b1111;
      tick();
`ifdef ADDARB_SATURATE_EN
      check("t3_sum_sat", 32'(rsp_sum), 32'h1F);
`else
      check("t3_sum_raw", 32'(rsp_sum), 32'h1E);
`endif
      check("t3_rsp_id", 32'(rsp_id), 32'h1);
      held_sum = rsp_sum;
      held_id  = rsp_id;
      for (int n = 0; n < 5; n++) begin
         tick();
         check("t4_hold_valid", 32'(rsp_valid), 32'h1);
         check("t4_hold_id",    32'(rsp_id),    32'(held_id));
         check("t4_hold_sum",   32'(rsp_sum),   32'(held_sum));
         check("t4_hold_ready", 32'(req_ready), 32'h0);
         check("t4_hold_busy",  32'(busy),      32'h1);
      end
      rsp_ready = 1'b1;
      tick();
      check("t4_idle_valid", 32'(rsp_valid), 32'h0);
      check("t4_idle_busy",  32'(busy),      32'h0);
      check("t4_next_grant", 32'(req_ready), 32'h4);

      // Reset while in EXEC discards the operation and the pointer
      tick();
      check("t5_in_exec", 32'(busy), 32'h1);
      req_valid = 4'b0000;
      rst_n     = 1'b0;
      #1;
      check("t5_rst_valid", 32'(rsp_valid), 32'h0);
      check("t5_rst_busy",  32'(busy),      32'h0);
      check("t5_rst_sum",   32'(rsp_sum),   32'h0);
      check("t5_rst_id",    32'(rsp_id),    32'h0);
      check("t5_rst_ready", 32'(req_ready), 32'h0);
      tick();
      check("t5_no_rsp", 32'(rsp_valid), 32'h0);
      rst_n     = 1'b1;
      req_valid = 4'b1010;
      req_a     = 16'h0090;
      req_b     = 16'h0030;
      #1;
      check("t5_first_grant", 32'(req_ready), 32'h2);
      tick();
      req_valid = 4'b0000;
      tick();
      check("t5_rsp_id",  32'(rsp_id),  32'h1);
      check("t5_rsp_sum", 32'(rsp_sum), 32'h0C);
      tick();

      // Requester 3 raises and drops valid while requester 0 is served
      req_valid = 4'b0001;
      req_a     = 16'h0002;
      req_b     = 16'h0003;
      #1;
      check("t6_grant0", 32'(req_ready), 32'h1);
      tick();
      req_valid = 4'b1000;
      tick();
      req_valid = 4'b0000;
      check("t6_rsp_id",  32'(rsp_id),  32'h0);
      check("t6_rsp_sum", 32'(rsp_sum), 32'h05);
      tick();
      for (int n = 0; n < 4; n++) begin
         check("t6_no_grant", 32'(req_ready), 32'h0);
         check("t6_no_rsp",   32'(rsp_valid), 32'h0);
         check("t6_idle",     32'(busy),      32'h0);
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
